icache: RTL and testbench

Direct-mapped, read-only instruction cache that answers the fetch stage's instruction requests and refills from the memory controller on a miss. It sits between the datapath fetch port (driven by the program counter's address) and the instruction side of the memory controller. Hits return data in the request cycle. Misses stall the fetch stage until the block is filled.

---
 rtl/cpu_types_pkg.sv | 27 ++
 rtl/cache_if.sv | 30 +++
 rtl/icache.sv | 84 ++++++++
 tb/tb_icache.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word, icache address split, frame and FSM state.
// Imported by the icache, its interface users and the bench.
package cpu_types_pkg;

    localparam int ITAG_W = 26;
    localparam int IIDX_W = 4;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        word_t             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE,
        FILL
    } istate_t;

endpackage

// File: rtl/cache_if.sv
// Fetch-side cache bundle: datapath request/response and memory refill.
// Modports: icache (the cache), dp (fetch stage), ctrl (memory ctrl).
interface cache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport icache (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport dp (
        output imemREN, imemaddr,
        input  ihit, imemload
    );

    modport ctrl (
        input  iREN, iaddr,
        output iwait, iload
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped read-only icache, one word per frame, register frames.
// Ports: CLK, nRST (async low), cif (cache_if.icache: fetch + refill).
module icache #(
    parameter int SETS  = 16,
    parameter int IDX_W = $clog2(SETS),
    parameter int TAG_W = 30 - IDX_W
) (
    input logic    CLK,
    input logic    nRST,
    cache_if.icache cif
);
    import cpu_types_pkg::*;

    istate_t       state, nstate;
    word_t         miss_addr;
    icache_frame_t frames [SETS];
    icachef_t      req;
    icache_frame_t cur;
    logic [IDX_W-1:0] idx, fidx;
    logic [TAG_W-1:0] tag, ftag;
    logic          hit, fill, miss;
    logic          unused_bytoff;

    assign req           = icachef_t'(cif.imemaddr);
    assign idx           = req.idx;
    assign tag           = req.tag;
    assign unused_bytoff = ^req.bytoff;
    assign cur           = frames[idx];
    assign hit           = cif.imemREN & cur.valid & (cur.tag == tag);

    assign fidx = miss_addr[IDX_W+1:2];
    assign ftag = miss_addr[31:IDX_W+2];

    // Unqualified: the datapath only trusts it while ihit is high.
    assign cif.imemload = cur.data;
    assign cif.iaddr    = miss_addr;

    always_comb begin
        nstate   = state;
        cif.ihit = 1'b0;
        cif.iREN = 1'b0;
        fill     = 1'b0;
        miss     = 1'b0;
        unique case (state)
            IDLE: begin
                cif.ihit = hit;
                if (cif.imemREN && !hit) begin
                    miss   = 1'b1;
                    nstate = FILL;
                end
            end
            FILL: begin
                cif.iREN = 1'b1;
                // Fill runs to completion even if the PC moves away.
                if (!cif.iwait) begin
                    fill   = 1'b1;
                    nstate = IDLE;
                end
            end
            default: nstate = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            miss_addr <= '0;
        end else begin
            state <= nstate;
            if (miss)
                miss_addr <= {cif.imemaddr[31:2], 2'b00};
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < SETS; i++)
                frames[i] <= '0;
        end else if (fill) begin
            frames[fidx] <= '{valid: 1'b1, tag: ftag, data: cif.iload};
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache.
// Drives fetch and refill sides of cache_if; checks at negedge + 1.
module tb_icache;
    import cpu_types_pkg::*;

    logic CLK;
    logic nRST;
    int   pass_cnt;
    int   total_cnt;

    cache_if cif ();

    icache dut (
        .CLK  (CLK),
        .nRST (nRST),
        .cif  (cif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic word_t mdata(input word_t a);
        return a ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string tag, input word_t obs, input word_t exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Move to the next sampling point (away from the rising edge).
    task automatic step();
        @(negedge CLK);
    endtask

    initial begin
        pass_cnt      = 0;
        total_cnt     = 0;
        nRST          = 1'b0;
        cif.imemREN   = 1'b0;
        cif.imemaddr  = '0;
        cif.iwait     = 1'b1;
        cif.iload     = '0;

        // Reset state
        step(); #1;
        chk("rst_ihit", {31'd0, cif.ihit}, 32'd0);
        chk("rst_iREN", {31'd0, cif.iREN}, 32'd0);
        chk("rst_iaddr", cif.iaddr, 32'd0);
        chk("rst_imemload", cif.imemload, 32'd0);
        step();
        nRST = 1'b1;

        // Cold miss on 0x40, three wait cycles
        step();
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0040;
        cif.iload    = 32'h2402_0001;
        cif.iwait    = 1'b1;
        #1;
        chk("cold_c0_ihit", {31'd0, cif.ihit}, 32'd0);
        chk("cold_c0_iREN", {31'd0, cif.iREN}, 32'd0);
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 4) cif.iwait = 1'b0;
            #1;
            chk($sformatf("cold_c%0d_iREN", c), {31'd0, cif.iREN}, 32'd1);
            chk($sformatf("cold_c%0d_iaddr", c), cif.iaddr, 32'h40);
            chk($sformatf("cold_c%0d_ihit", c), {31'd0, cif.ihit}, 32'd0);
        end
        step();
        cif.iwait = 1'b1;
        #1;
        chk("cold_c5_ihit", {31'd0, cif.ihit}, 32'd1);
        chk("cold_c5_data", cif.imemload, 32'h2402_0001);
        chk("cold_c5_iREN", {31'd0, cif.iREN}, 32'd0);

        // Hit with byte offset ignored
        step();
        cif.imemaddr = 32'h0000_0042;
        #1;
        chk("hit42_ihit", {31'd0, cif.ihit}, 32'd1);
        chk("hit42_data", cif.imemload, 32'h2402_0001);
        chk("hit42_iREN", {31'd0, cif.iREN}, 32'd0);

        // Conflict: 0x440 evicts 0x40 (both idx 0)
        step();
        cif.imemaddr = 32'h0000_0440;
        cif.iload    = 32'h1111_1111;
        cif.iwait    = 1'b0;
        #1;
        chk("conf_c0_ihit", {31'd0, cif.ihit}, 32'd0);
        step(); #1;
        chk("conf_c1_iREN", {31'd0, cif.iREN}, 32'd1);
        chk("conf_c1_iaddr", cif.iaddr, 32'h440);
        step(); #1;
        chk("conf_c2_ihit", {31'd0, cif.ihit}, 32'd1);
        chk("conf_c2_data", cif.imemload, 32'h1111_1111);
        step();
        cif.imemaddr = 32'h0000_0040;
        cif.iload    = 32'h2402_0001;
        #1;
        chk("evict40_ihit", {31'd0, cif.ihit}, 32'd0);
        step(); #1;
        chk("evict40_iaddr", cif.iaddr, 32'h40);
        step(); #1;
        chk("refill40_data", cif.imemload, 32'h2402_0001);

        // Redirect during fill of 0x80
        step();
        cif.imemaddr = 32'h0000_0080;
        cif.iload    = 32'hAAAA_0080;
        cif.iwait    = 1'b1;
        #1;
        chk("redir_c0_ihit", {31'd0, cif.ihit}, 32'd0);
        step(); #1;
        chk("redir_c1_iaddr", cif.iaddr, 32'h80);
        step();
        cif.imemaddr = 32'h0000_0100;
        #1;
        chk("redir_c2_iaddr", cif.iaddr, 32'h80);
        chk("redir_c2_ihit", {31'd0, cif.ihit}, 32'd0);
        step();
        cif.iwait = 1'b0;
        #1;
        chk("redir_c3_iaddr", cif.iaddr, 32'h80);
        step();
        cif.iwait = 1'b1;
        cif.iload = 32'hBBBB_0100;
        #1;
        chk("redir_c4_ihit", {31'd0, cif.ihit}, 32'd0);
        chk("redir_c4_iREN", {31'd0, cif.iREN}, 32'd0);
        step();
        cif.iwait = 1'b0;
        #1;
        chk("redir_c5_iaddr", cif.iaddr, 32'h100);
        step(); #1;
        chk("redir_100_ihit", {31'd0, cif.ihit}, 32'd1);
        chk("redir_100_data", cif.imemload, 32'hBBBB_0100);
        // 0x100 shares idx 0 with 0x80, so 0x80 is gone now.
        step();
        cif.imemaddr = 32'h0000_0080;
        cif.iload    = 32'hAAAA_0080;
        #1;
        chk("redir_80_evicted", {31'd0, cif.ihit}, 32'd0);
        step(); #1;
        chk("redir_80_iaddr", cif.iaddr, 32'h80);
        step(); #1;
        chk("redir_80_data", cif.imemload, 32'hAAAA_0080);

        // Fill 0x40 again, then reset in the middle of a 0x44 fill
        step();
        cif.imemaddr = 32'h0000_0040;
        cif.iload    = 32'h2402_0001;
        step();
        step(); #1;
        chk("pre_rst_40_hit", {31'd0, cif.ihit}, 32'd1);
        step();
        cif.imemaddr = 32'h0000_0044;
        cif.iload    = 32'hCCCC_0044;
        cif.iwait    = 1'b1;
        step(); #1;
        chk("mid_rst_iREN_pre", {31'd0, cif.iREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("mid_rst_iREN", {31'd0, cif.iREN}, 32'd0);
        chk("mid_rst_ihit", {31'd0, cif.ihit}, 32'd0);
        step();
        cif.imemREN = 1'b0;
        nRST        = 1'b1;
        step();
        cif.imemREN  = 1'b1;
        cif.imemaddr = 32'h0000_0040;
        cif.iload    = mdata(32'h40);
        cif.iwait    = 1'b0;
        #1;
        chk("post_rst_40_miss", {31'd0, cif.ihit}, 32'd0);
        step(); #1;
        chk("post_rst_40_iREN", {31'd0, cif.iREN}, 32'd1);

        // Zero-wait sweep of all 16 indices, then a hit-only sweep
        for (int i = 0; i < 16; i++) begin
            step();
            cif.imemaddr = 32'h0000_1000 + 32'(i * 4);
            cif.iload    = mdata(cif.imemaddr);
            #1;
            chk($sformatf("sw1_%0d_miss", i), {31'd0, cif.ihit}, 32'd0);
            step(); #1;
            chk($sformatf("sw1_%0d_iaddr", i), cif.iaddr,
                32'h0000_1000 + 32'(i * 4));
            step(); #1;
            chk($sformatf("sw1_%0d_hit", i), {31'd0, cif.ihit}, 32'd1);
            chk($sformatf("sw1_%0d_data", i), cif.imemload,
                mdata(32'h0000_1000 + 32'(i * 4)));
        end
        cif.iload = 32'hDEAD_BEEF;
        for (int i = 0; i < 16; i++) begin
            step();
            cif.imemaddr = 32'h0000_1000 + 32'(i * 4);
            #1;
            chk($sformatf("sw2_%0d_hit", i), {31'd0, cif.ihit}, 32'd1);
            chk($sformatf("sw2_%0d_iREN", i), {31'd0, cif.iREN}, 32'd0);
            chk($sformatf("sw2_%0d_data", i), cif.imemload,
                mdata(32'h0000_1000 + 32'(i * 4)));
        end

        step();
        cif.imemREN = 1'b0;
        step();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
